// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions.
// Holds the fetch FSM state type, the special instruction encodings and the
// IF/ID pipeline register payload that decode also consumes.
package cpu_pkg;

    typedef enum logic [1:0] {
        StRun,
        StHalted,
        StFault
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instruction;
    } if_id_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: control from the pipeline, instruction-memory port and the
// IF/ID outputs towards decode.
//   master: the fetch stage (drives pc, imem_addr, IF/ID, status).
//   slave : the surrounding pipeline / memory (drives stall, redirect, imem data).
interface instruction_fetch_if #(
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  stall;
    logic                  redirect_valid;
    logic [31:0]           redirect_target;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_instruction;
    logic [31:0]           pc;
    logic                  if_id_valid;
    logic [31:0]           if_id_pc;
    logic [31:0]           if_id_instruction;
    logic                  halted;
    logic                  fetch_fault;

    modport master (
        input  stall, redirect_valid, redirect_target, imem_instruction,
        output imem_addr, pc, if_id_valid, if_id_pc, if_id_instruction, halted, fetch_fault
    );

    modport slave (
        output stall, redirect_valid, redirect_target, imem_instruction,
        input  imem_addr, pc, if_id_valid, if_id_pc, if_id_instruction, halted, fetch_fault
    );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, reset : clock, asynchronous active-high reset
//   hold_i     : keep the current contents (stall)
//   bubble_i   : insert a bubble (valid=0, NOP instruction, pc kept); beats hold_i
//   d_i / q_o  : register payload in / out
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   hold_i,
    input  logic   bubble_i,
    input  if_id_t d_i,
    output if_id_t q_o
);
    if_id_t q_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q.valid       <= 1'b0;
            q_q.pc          <= 32'h0;
            q_q.instruction <= NOP_WORD;
        end else if (bubble_i) begin
            q_q.valid       <= 1'b0;
            q_q.instruction <= NOP_WORD;
        end else if (!hold_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses instruction memory, captures the fetched
// word into IF/ID and tracks RUN / HALTED / FAULT.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : instruction_fetch_if master (stall, redirect, imem port, IF/ID, status)
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input logic                 clk,
    input logic                 reset,
    instruction_fetch_if.master bus
);
    import cpu_pkg::*;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         hold, bubble, in_range;
    if_id_t       if_id_d, if_id_q;

    // Anything above the memory's byte span is a fault.
    assign in_range = (pc_q >> (ADDR_WIDTH + 2)) == 32'h0;

    assign if_id_d = '{valid: 1'b1, pc: pc_q, instruction: bus.imem_instruction};

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        hold    = 1'b0;
        bubble  = 1'b0;
        if (bus.redirect_valid) begin
            pc_d    = bus.redirect_target & ~32'h3;
            state_d = StRun;
            bubble  = 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (bus.stall) begin
                        hold = 1'b1;
                    end else if (!in_range) begin
                        bubble  = 1'b1;
                        state_d = StFault;
                    end else if (bus.imem_instruction == HALT_WORD) begin
                        // Halt word goes downstream valid; PC parks on it.
                        state_d = StHalted;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
                default: bubble = 1'b1;  // HALTED / FAULT ignore stall
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state_q <= StRun;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    if_id_reg #(
        .NOP_WORD(NOP_WORD)
    ) u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .hold_i  (hold),
        .bubble_i(bubble),
        .d_i     (if_id_d),
        .q_o     (if_id_q)
    );

    assign bus.imem_addr         = pc_q[ADDR_WIDTH+1:2];
    assign bus.pc                = pc_q;
    assign bus.if_id_valid       = if_id_q.valid;
    assign bus.if_id_pc          = if_id_q.pc;
    assign bus.if_id_instruction = if_id_q.instruction;
    assign bus.halted            = (state_q == StHalted);
    assign bus.fetch_fault       = (state_q == StFault);
endmodule
